// File: rtl/updown_mod_counter.sv
// Up/down modulo counter with variable step, programmable inclusive bound, load and sticky flags.
// Define UPDOWN_CNT_SATURATE_EN to saturate at the bounds; leave it undefined to wrap.
module updown_mod_counter #(
  parameter int WIDTH  = 32,
  parameter int STEP_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              ctrl,
  input  logic [STEP_W-1:0] step,
  input  logic [WIDTH-1:0]  max_val,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_flags,
  output logic [WIDTH-1:0]  cnt,
  output logic              tc,
  output logic              ovf,
  output logic              udf,
  output logic              at_max,
  output logic              at_zero
);

  typedef enum logic [2:0] {
    ACT_HOLD   = 3'd0,
    ACT_LOAD   = 3'd1,
    ACT_ADD    = 3'd2,
    ACT_SUB    = 3'd3,
    ACT_UP_BND = 3'd4,
    ACT_DN_BND = 3'd5
  } act_t;

  logic [WIDTH-1:0] cnt_r;
  logic             tc_r;
  logic             ovf_r;
  logic             udf_r;

  logic [WIDTH-1:0] cnt_nxt_s;
  logic             tc_nxt_s;
  logic             ovf_nxt_s;
  logic             udf_nxt_s;

  logic [WIDTH-1:0] step_ext_s;
  logic [WIDTH:0]   up_sum_s;
  logic [WIDTH-1:0] dn_diff_s;
  logic [WIDTH-1:0] load_clip_s;
  logic [WIDTH-1:0] up_target_s;
  logic [WIDTH-1:0] dn_target_s;
  logic             step_zero_s;
  logic             above_max_s;
  logic             up_bnd_s;
  logic             dn_bnd_s;
  logic             up_evt_s;
  logic             dn_evt_s;
  act_t             act_s;

  assign step_ext_s  = WIDTH'(step);
  assign step_zero_s = (step == {STEP_W{1'b0}});
  assign above_max_s = (cnt_r > max_val);

  // One extra bit keeps cnt+step exact even when both operands are near 2^WIDTH.
  assign up_sum_s    = {1'b0, cnt_r} + {1'b0, step_ext_s};
  assign up_bnd_s    = (up_sum_s > {1'b0, max_val});
  assign dn_bnd_s    = (cnt_r < step_ext_s);
  assign dn_diff_s   = cnt_r - step_ext_s;
  assign load_clip_s = (load_val > max_val) ? max_val : load_val;

`ifdef UPDOWN_CNT_SATURATE_EN
  assign up_target_s = max_val;
  assign dn_target_s = {WIDTH{1'b0}};
`else
  assign up_target_s = {WIDTH{1'b0}};
  assign dn_target_s = max_val;
`endif

  // Select this cycle's action: load beats count, zero step holds, an out-of-range count is an up event.
  always_comb begin
    act_s = ACT_HOLD;
    if (load) begin
      act_s = ACT_LOAD;
    end else if (en && !step_zero_s) begin
      if (above_max_s) begin
        act_s = ACT_UP_BND;
      end else if (ctrl) begin
        act_s = up_bnd_s ? ACT_UP_BND : ACT_ADD;
      end else begin
        act_s = dn_bnd_s ? ACT_DN_BND : ACT_SUB;
      end
    end else begin
      act_s = ACT_HOLD;
    end
  end

  // Next count and boundary events for the selected action.
  always_comb begin
    cnt_nxt_s = cnt_r;
    up_evt_s  = 1'b0;
    dn_evt_s  = 1'b0;
    case (act_s)
      ACT_LOAD:   cnt_nxt_s = load_clip_s;
      ACT_ADD:    cnt_nxt_s = up_sum_s[WIDTH-1:0];
      ACT_SUB:    cnt_nxt_s = dn_diff_s;
      ACT_UP_BND: begin
        cnt_nxt_s = up_target_s;
        up_evt_s  = 1'b1;
      end
      ACT_DN_BND: begin
        cnt_nxt_s = dn_target_s;
        dn_evt_s  = 1'b1;
      end
      ACT_HOLD:   cnt_nxt_s = cnt_r;
      default:    cnt_nxt_s = cnt_r;
    endcase
  end

  // Sticky flags: a set event in the same cycle outranks clr_flags.
  always_comb begin
    tc_nxt_s  = up_evt_s | dn_evt_s;
    ovf_nxt_s = up_evt_s | (ovf_r & ~clr_flags);
    udf_nxt_s = dn_evt_s | (udf_r & ~clr_flags);
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= {WIDTH{1'b0}};
      tc_r  <= 1'b0;
      ovf_r <= 1'b0;
      udf_r <= 1'b0;
    end else begin
      cnt_r <= cnt_nxt_s;
      tc_r  <= tc_nxt_s;
      ovf_r <= ovf_nxt_s;
      udf_r <= udf_nxt_s;
    end
  end

  assign cnt     = cnt_r;
  assign tc      = tc_r;
  assign ovf     = ovf_r;
  assign udf     = udf_r;
  assign at_max  = (cnt_r == max_val);
  assign at_zero = (cnt_r == {WIDTH{1'b0}});

endmodule

// File: tb/tb_updown_mod_counter.sv
// Randomized self-checking bench for updown_mod_counter against an arithmetic reference model.
// Honours UPDOWN_CNT_SATURATE_EN the same way as the design.
module tb_updown_mod_counter;

  localparam int WIDTH  = 8;
  localparam int STEP_W = 4;
`ifdef UPDOWN_CNT_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n;
  logic              en;
  logic              ctrl;
  logic [STEP_W-1:0] step;
  logic [WIDTH-1:0]  max_val;
  logic              load;
  logic [WIDTH-1:0]  load_val;
  logic              clr_flags;
  logic [WIDTH-1:0]  cnt;
  logic              tc, ovf, udf, at_max, at_zero;

  int n_checks = 0;
  int n_pass   = 0;

  int m_cnt;
  bit m_tc, m_ovf, m_udf;

  logic [WIDTH+4:0] got_v;
  assign got_v = {cnt, tc, ovf, udf, at_max, at_zero};

  updown_mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ctrl(ctrl), .step(step),
    .max_val(max_val), .load(load), .load_val(load_val), .clr_flags(clr_flags),
    .cnt(cnt), .tc(tc), .ovf(ovf), .udf(udf), .at_max(at_max), .at_zero(at_zero)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_cnt = 0; m_tc = 1'b0; m_ovf = 1'b0; m_udf = 1'b0;
  endtask

  // Reference behaviour, evaluated with the inputs present at the rising edge.
  task automatic model_update();
    int mx, st;
    bit up_e, dn_e;
    mx = int'(max_val);
    st = int'(step);
    up_e = 1'b0;
    dn_e = 1'b0;
    if (load) begin
      m_cnt = (int'(load_val) > mx) ? mx : int'(load_val);
    end else if (en && st != 0) begin
      if (m_cnt > mx)           up_e = 1'b1;
      else if (ctrl) begin
        if (m_cnt + st > mx)    up_e = 1'b1;
        else                    m_cnt = m_cnt + st;
      end else begin
        if (m_cnt < st)         dn_e = 1'b1;
        else                    m_cnt = m_cnt - st;
      end
    end
    if (up_e) m_cnt = SAT ? mx : 0;
    if (dn_e) m_cnt = SAT ? 0 : mx;
    m_tc  = up_e | dn_e;
    m_ovf = up_e | (m_ovf & ~clr_flags);
    m_udf = dn_e | (m_udf & ~clr_flags);
  endtask

  function automatic logic [WIDTH+4:0] exp_vec();
    logic [WIDTH-1:0] c;
    c = m_cnt[WIDTH-1:0];
    return {c, m_tc, m_ovf, m_udf, (m_cnt == int'(max_val)), (m_cnt == 0)};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle_inputs();
    en = 1'b0; load = 1'b0; clr_flags = 1'b0; ctrl = 1'b1; step = 4'd1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; idle_inputs(); max_val = 8'd9; load_val = 8'd0;
    model_reset();
    #2;
    n_checks++;
    if (got_v !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL reset: got %h exp %h", got_v, {8'd0, 5'b00001});
    else n_pass++;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_wrap_up();
    max_val = 8'd9; step = 4'd1; ctrl = 1'b1; en = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      n_checks++;
      if (got_v !== exp_vec()) $display("FAIL wrap_up[%0d]: got %h exp %h", i, got_v, exp_vec());
      else n_pass++;
      if (i == 10) begin
        n_checks++;
        if (cnt !== (SAT ? 8'd9 : 8'd0) || tc !== 1'b1)
          $display("FAIL wrap_up_edge: got cnt=%0d tc=%b exp cnt=%0d tc=1", cnt, tc, SAT ? 9 : 0);
        else n_pass++;
      end
    end
    n_checks++;
    if (ovf !== 1'b1 || udf !== 1'b0) $display("FAIL wrap_up_ovf: got ovf=%b udf=%b exp 1 0", ovf, udf);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_down_load();
    max_val = 8'd9; load_val = 8'd4; load = 1'b1; clr_flags = 1'b1;
    tick();
    load = 1'b0; clr_flags = 1'b0; en = 1'b1; ctrl = 1'b0; step = 4'd3;
    n_checks++;
    if (cnt !== 8'd4 || tc !== 1'b0) $display("FAIL down_load: got cnt=%0d tc=%b exp 4 0", cnt, tc);
    else n_pass++;
    tick();
    n_checks++;
    if (got_v !== exp_vec() || cnt !== 8'd1) $display("FAIL down_step: got %h exp %h", got_v, exp_vec());
    else n_pass++;
    tick();
    n_checks++;
    if (cnt !== (SAT ? 8'd0 : 8'd9) || tc !== 1'b1 || udf !== 1'b1 || got_v !== exp_vec())
      $display("FAIL down_bnd: got %h exp %h", got_v, exp_vec());
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_load_priority();
    logic o, u;
    o = ovf; u = udf;
    max_val = 8'd15; load_val = 8'd20; load = 1'b1; en = 1'b1; ctrl = 1'b1; step = 4'd15;
    tick();
    n_checks++;
    if (cnt !== 8'd15 || tc !== 1'b0 || ovf !== o || udf !== u)
      $display("FAIL load_prio: got cnt=%0d tc=%b ovf=%b udf=%b exp 15 0 %b %b", cnt, tc, ovf, udf, o, u);
    else n_pass++;
    n_checks++;
    if (got_v !== exp_vec()) $display("FAIL load_prio_model: got %h exp %h", got_v, exp_vec());
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_lowered_bound();
    max_val = 8'd20; load_val = 8'd12; load = 1'b1; clr_flags = 1'b1;
    tick();
    load = 1'b0; clr_flags = 1'b0; max_val = 8'd5; en = 1'b1; ctrl = 1'b0; step = 4'd1;
    tick();
    n_checks++;
    if (cnt !== (SAT ? 8'd5 : 8'd0) || ovf !== 1'b1 || udf !== 1'b0 || tc !== 1'b1)
      $display("FAIL lowered_bound: got cnt=%0d ovf=%b udf=%b tc=%b", cnt, ovf, udf, tc);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_zero_step();
    max_val = 8'd30; load_val = 8'd30; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; step = 4'd0;
    for (int i = 0; i < 2; i++) begin
      ctrl = i[0];
      tick();
      n_checks++;
      if (cnt !== 8'd30 || tc !== 1'b0 || got_v !== exp_vec())
        $display("FAIL zero_step[%0d]: got %h exp %h", i, got_v, exp_vec());
      else n_pass++;
    end
    idle_inputs();
  endtask

  task automatic test_async_reset();
    max_val = 8'd20; load_val = 8'd7; load = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; ctrl = 1'b1; step = 4'd2;
    #1 rst_n = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if (got_v !== {8'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1})
      $display("FAIL async_reset: got %h exp %h", got_v, {8'd0, 5'b00001});
    else n_pass++;
    #1 rst_n = 1'b1;
    tick();
    n_checks++;
    if (cnt !== 8'd2 || got_v !== exp_vec()) $display("FAIL reset_resume: got %h exp %h", got_v, exp_vec());
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_clr_vs_set();
    max_val = 8'd3; load_val = 8'd3; load = 1'b1; clr_flags = 1'b1;
    tick();
    load = 1'b0; en = 1'b1; ctrl = 1'b1; step = 4'd1; clr_flags = 1'b1;
    tick();
    n_checks++;
    if (ovf !== 1'b1 || tc !== 1'b1) $display("FAIL clr_vs_set: got ovf=%b tc=%b exp 1 1", ovf, tc);
    else n_pass++;
    en = 1'b0;
    tick();
    n_checks++;
    if (ovf !== 1'b0 || tc !== 1'b0) $display("FAIL clr_alone: got ovf=%b tc=%b exp 0 0", ovf, tc);
    else n_pass++;
    idle_inputs();
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 7) == 0)
        max_val = ($urandom_range(0, 9) == 0) ? 8'(255 - $urandom_range(0, 3)) : 8'($urandom_range(0, 40));
      en        = ($urandom_range(0, 3) != 0);
      ctrl      = 1'($urandom_range(0, 1));
      step      = 4'($urandom_range(0, 15));
      load      = ($urandom_range(0, 15) == 0);
      load_val  = 8'($urandom_range(0, 255));
      clr_flags = ($urandom_range(0, 7) == 0);
      tick();
      n_checks++;
      if (got_v !== exp_vec()) $display("FAIL random[%0d]: got %h exp %h", i, got_v, exp_vec());
      else n_pass++;
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_down_load();
    test_load_priority();
    test_lowered_bound();
    test_zero_step();
    test_async_reset();
    test_clr_vs_set();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/updown_mod_counter.md
UPDOWN_MOD_COUNTER -- requirements
Module: updown_mod_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 32, counter and bound width in bits (2..64).
REQ-002 SHALL have parameter STEP_W, default 8, step input width (1..WIDTH).
REQ-003 SHALL have port clk  input  1  rising-edge clock, sole clock.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable.
REQ-006 SHALL have port ctrl  input  1  direction: 1 = up, 0 = down.
REQ-007 SHALL have port step  input  STEP_W  unsigned increment/decrement amount.
REQ-008 SHALL have port max_val  input  WIDTH  inclusive upper bound; count range is 0..max_val.
REQ-009 SHALL have port load  input  1  synchronous load strobe.
REQ-010 SHALL have port load_val  input  WIDTH  load value.
REQ-011 SHALL have port clr_flags  input  1  clears sticky flags.
REQ-012 SHALL have port cnt  output  WIDTH  registered count.
REQ-013 SHALL have port tc  output  1  registered one-cycle boundary pulse.
REQ-014 SHALL have port ovf  output  1  sticky up-boundary flag.
REQ-015 SHALL have port udf  output  1  sticky down-boundary flag.
REQ-016 SHALL have port at_max  output  1  combinational, cnt == max_val.
REQ-017 SHALL have port at_zero  output  1  combinational, cnt == 0.

Function
REQ-018 SHALL update cnt one cycle after the qualifying edge; priority load > en > hold.
REQ-019 SHALL, on load, set cnt = min(load_val, max_val), with no tc/ovf/udf effect.
REQ-020 SHALL, with en=1 and step=0, hold cnt with no flag effect.
REQ-021 SHALL, with en=1 and cnt > max_val (bound lowered), set cnt to the boundary value, pulse tc and set ovf, in either direction.
REQ-022 SHALL, up (ctrl=1), when cnt > max_val - step (true whenever step > max_val), take the up-boundary event; otherwise cnt = cnt + step.
REQ-023 SHALL, down (ctrl=0), when cnt < step, take the down-boundary event; otherwise cnt = cnt - step.
REQ-024 SHALL, on an up-boundary event, assert tc for exactly the next cycle and set ovf; on a down-boundary event, assert tc and set udf.
REQ-025 SHALL zero-extend step to WIDTH; no intermediate result may exceed WIDTH+1 bits or be silently truncated.
REQ-026 SHALL, when clr_flags and a set event coincide, leave the flag set (set beats clear).
REQ-027 SHALL deassert tc in any cycle without a boundary event, including load cycles.

Reset
REQ-028 SHALL, while rst_n=0, immediately force cnt=0, tc=0, ovf=0, udf=0, independent of clk.
REQ-029 SHALL resume counting on the first rising clk edge after rst_n deasserts; reset mid-count discards the pending update.

Configuration
REQ-030 SHALL use macro UPDOWN_CNT_SATURATE_EN to select boundary behaviour.
REQ-031 SHALL, with UPDOWN_CNT_SATURATE_EN undefined, wrap: up-boundary -> cnt=0, down-boundary -> cnt=max_val.
REQ-032 SHALL, with UPDOWN_CNT_SATURATE_EN defined, saturate: up-boundary -> cnt=max_val, down-boundary -> cnt=0; tc/ovf/udf still fire on every boundary event, including repeated events while pinned.

Verification
REQ-033 SHALL cover: max_val=9, step=1, en=1, ctrl=1 from 0 for 12 cycles -> cnt 0..9,0,1; tc high one cycle after 9->0; ovf=1 (wrap build).
REQ-034 SHALL cover: max_val=9, step=3, ctrl=0, load_val=4 -> cnt 4,1, then wrap to 9 (saturate build: 0), udf=1, tc pulse.
REQ-035 SHALL cover: load=1 and en=1 together with load_val=20, max_val=15 -> cnt=15, tc=0, flags unchanged.
REQ-036 SHALL cover: cnt=12, max_val lowered to 5, en=1, ctrl=0 -> cnt=0 (wrap) or 5 (saturate), ovf=1.
REQ-037 SHALL cover: rst_n pulled low for 3 ns mid-cycle with cnt=7 -> cnt=0, tc=ovf=udf=0 before the next clk edge.
REQ-038 SHALL cover: clr_flags=1 in the same cycle as an up-boundary event -> ovf remains 1; clr_flags alone next cycle -> ovf=0.
